seg_scan_driver: RTL and testbench

Downstream display stage of the SIMPLE 16-bit processor board. Takes four 16-bit debug words from the core (fetched instruction, PC, register read port, control flags), snapshots them on request, and drives an 8-digit multiplexed hex 7-segment display by time-division scan. Snapshots apply only at frame boundaries, so the display never tears.

---
 rtl/seg_scan_driver_pkg.sv | 20 ++
 rtl/seg_scan_driver_hex_to_seg.sv | 16 +
 rtl/seg_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: digit count,
// hex-to-segment table and the all-off patterns for each polarity.
package seg_pkg;

  localparam int DIGITS = 8;

  // gfedcba patterns, entry 0 at the LSB end
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  localparam logic [7:0] SEG_OFF_LOW  = 8'hFF;
  localparam logic [7:0] SEG_OFF_HIGH = 8'h00;
  localparam logic [7:0] DIG_OFF_LOW  = 8'hFF;
  localparam logic [7:0] DIG_OFF_HIGH = 8'h00;

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Nibble to gfedcba decoder with a blank override (all segments off).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup, forced dark when the digit is blanked
  always_comb begin
    seg = HEX_SEG[nib];
    if (blank) seg = 7'h00;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed hex display driver. Four debug words are
// snapshotted on load and only become visible at a frame boundary, so
// a frame never shows a mix of old and new values.
// Build option: SEG_SCAN_LZB_EN enables leading-zero blanking per half.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  input  logic [15:0] in_d,
  input  logic        load,
  input  logic        page,
  output logic        load_ack,
  output logic [7:0]  seg_out,
  output logic [7:0]  dig_sel
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
  localparam logic [7:0]    SEG_OFF   = ACTIVE_LOW ? SEG_OFF_LOW : SEG_OFF_HIGH;
  localparam logic [7:0]    DIG_OFF   = ACTIVE_LOW ? DIG_OFF_LOW : DIG_OFF_HIGH;

  logic [PW-1:0] presc;
  logic [DW-1:0] dig_idx;
  logic          tick;
  logic          frame_end;

  logic [15:0] sh_a, sh_b, sh_c, sh_d;
  logic [15:0] disp_a, disp_b, disp_c, disp_d;
  logic        pending;
  logic        page_q;

  logic [15:0] cur_word;
  logic [1:0]  nib_pos;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg7;
  logic [7:0]  seg_raw;
  logic [7:0]  dig_raw;

  assign tick      = (presc == PRESC_MAX);
  assign frame_end = tick && (dig_idx == DIG_LAST);

  // Slot prescaler and digit scan counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      dig_idx <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) dig_idx <= dig_idx + 1'b1;
    end
  end

  // Snapshot handshake: shadow captures, display updates only at frame end.
  // A load on the boundary cycle bypasses the shadow straight to display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_c     <= '0;
      sh_d     <= '0;
      disp_a   <= '0;
      disp_b   <= '0;
      disp_c   <= '0;
      disp_d   <= '0;
      pending  <= 1'b0;
      page_q   <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= frame_end && (load || pending);
      if (frame_end) page_q <= page;
      if (load && frame_end) begin
        disp_a  <= in_a;
        disp_b  <= in_b;
        disp_c  <= in_c;
        disp_d  <= in_d;
        pending <= 1'b0;
      end else if (load) begin
        sh_a    <= in_a;
        sh_b    <= in_b;
        sh_c    <= in_c;
        sh_d    <= in_d;
        pending <= 1'b1;
      end else if (frame_end && pending) begin
        disp_a  <= sh_a;
        disp_b  <= sh_b;
        disp_c  <= sh_c;
        disp_d  <= sh_d;
        pending <= 1'b0;
      end
    end
  end

  // Select the word and nibble for the digit currently being scanned
  always_comb begin
    if (dig_idx[2]) cur_word = page_q ? disp_c : disp_a;
    else            cur_word = page_q ? disp_d : disp_b;
    nib_pos = dig_idx[1:0];
    nib     = cur_word[{nib_pos, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
    // Blank when this nibble and everything above it in the half is zero;
    // the lowest digit of each half always shows.
    blank = (nib_pos != 2'd0) && ((cur_word >> {nib_pos, 2'b00}) == 16'h0000);
`else
    blank = 1'b0;
`endif
  end

  hex_to_seg u_hex_to_seg (
    .nib   (nib),
    .blank (blank),
    .seg   (seg7)
  );

  // Decimal point on digit 4 separates the two words
  always_comb begin
    seg_raw = {(dig_idx == DW'(4)), seg7};
    dig_raw = 8'h01 << dig_idx;
  end

  // Registered outputs with polarity applied at the flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg_out <= ACTIVE_LOW ? ~seg_raw : seg_raw;
      dig_sel <= ACTIVE_LOW ? ~dig_raw : dig_raw;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (CLK_DIV=4, active-low outputs).
// Reference model works from cycle arithmetic: slot = n/4, digit = slot%8,
// frame boundary on cycles where n%32 == 31.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic        load = 1'b0;
  logic        page = 1'b0;
  logic        load_ack;
  logic [7:0]  seg_out;
  logic [7:0]  dig_sel;

  int checks = 0;
  int failures = 0;
  int ack_seen = 0;

  logic [6:0]  tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          m_n;
  logic [15:0] m_disp [4];
  logic [15:0] m_sh [4];
  logic        m_pend;
  logic        m_pgq;

  seg_scan_driver #(.CLK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .load(load), .page(page), .load_ack(load_ack), .seg_out(seg_out), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_raw(input int k);
    logic [15:0] w, v;
    logic [6:0]  s;
    int p;
    if (k >= 4) w = m_pgq ? m_disp[2] : m_disp[0];
    else        w = m_pgq ? m_disp[3] : m_disp[1];
    p = k % 4;
    v = w >> (4 * p);
    s = tbl[v[3:0]];
`ifdef SEG_SCAN_LZB_EN
    if (p != 0 && v == 16'h0) s = 7'h00;
`endif
    return {(k == 4), s};
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_pend = 1'b0;
    m_pgq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_disp[i] = '0;
      m_sh[i] = '0;
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, m_n, got, exp);
    end
  endtask

  // One clock with the current inputs; model advances, outputs checked after the edge
  task automatic cyc(input logic ld);
    logic [7:0] es, ed;
    logic ea, bnd;
    int k;
    load = ld;
    k = (m_n / 4) % 8;
    es = ~exp_raw(k);
    ed = ~(8'h01 << k);
    bnd = (m_n % 32) == 31;
    ea = bnd && (ld || m_pend);
    if (ld && bnd) begin
      m_disp[0] = in_a; m_disp[1] = in_b; m_disp[2] = in_c; m_disp[3] = in_d;
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh[0] = in_a; m_sh[1] = in_b; m_sh[2] = in_c; m_sh[3] = in_d;
      m_pend = 1'b1;
    end else if (bnd && m_pend) begin
      for (int i = 0; i < 4; i++) m_disp[i] = m_sh[i];
      m_pend = 1'b0;
    end
    if (bnd) m_pgq = page;
    m_n++;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (load_ack === 1'b1) ack_seen++;
    chk8("seg_out", seg_out, es);
    chk8("dig_sel", dig_sel, ed);
    chk8("load_ack", {7'b0, load_ack}, {7'b0, ea});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic run_to_digit(input int d);
    for (int i = 0; i < 40 && ((m_n / 4) % 8) != d; i++) cyc(1'b0);
  endtask

  task automatic run_to_boundary();
    for (int i = 0; i < 40 && (m_n % 32) != 31; i++) cyc(1'b0);
  endtask

  initial begin
    int base;
    // Power-on reset
    #2 rst = 1'b1;
    #1;
    chk8("por_dig", dig_sel, 8'hFF);
    chk8("por_seg", seg_out, 8'hFF);
    @(posedge clk); @(posedge clk); #1;
    chk8("por_ack", {7'b0, load_ack}, 8'h00);
    rst = 1'b0;
    model_reset();
    run(10);

    // 1: reset in the middle of a frame, at digit 5
    run_to_digit(5);
    #2 rst = 1'b1;
    #1;
    chk8("rst_dig", dig_sel, 8'hFF);
    chk8("rst_seg", seg_out, 8'hFF);
    @(posedge clk); #1;
    chk8("rst_dig_hold", dig_sel, 8'hFF);
    chk8("rst_seg_hold", seg_out, 8'hFF);
    rst = 1'b0;
    model_reset();
    cyc(1'b0);
    chk8("rst_first_digit", dig_sel, 8'hFE);
    chk8("rst_first_seg", seg_out, 8'hC0);

    // 2: page 0, load 1234/ABCD mid-frame
    run(6);
    page = 1'b0;
    in_a = 16'h1234; in_b = 16'hABCD;
    ack_seen = 0;
    cyc(1'b1);
    base = 0;
    while (ack_seen == 0 && base < 64) begin
      cyc(1'b0);
      base++;
    end
    checks++;
    assert (ack_seen == 1) else begin
      failures++;
      $error("FAIL ack_after_load got=%0d exp=1", ack_seen);
    end
    run(32);

    // 3: two loads in one frame, last wins, single ack
    run_to_digit(1);
    ack_seen = 0;
    in_a = 16'h1111; cyc(1'b1);
    run(5);
    in_a = 16'h2222; cyc(1'b1);
    run(40);
    checks++;
    assert (ack_seen == 1) else begin
      failures++;
      $error("FAIL double_load_acks got=%0d exp=1", ack_seen);
    end

    // 4: load exactly on the boundary cycle
    run_to_boundary();
    in_a = 16'hBEEF;
    ack_seen = 0;
    cyc(1'b1);
    run(40);
    checks++;
    assert (ack_seen == 1) else begin
      failures++;
      $error("FAIL boundary_load_acks got=%0d exp=1", ack_seen);
    end

    // 5: load C/D, then switch page at digit 3 of a later frame
    in_c = 16'h0F0F; in_d = 16'h0000;
    cyc(1'b1);
    run(34);
    run_to_digit(3);
    page = 1'b1;
    run(64);

    // Randomized loads, values and page flips
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) page = ~page;
      if ($urandom_range(0, 7) == 0) begin
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_c = 16'($urandom); in_d = 16'($urandom);
        if ($urandom_range(0, 3) == 0) in_b = 16'($urandom_range(0, 255));
        cyc(1'b1);
      end else begin
        cyc(1'b0);
      end
    end

    // 6: leading-zero case (blanks only when the option is built in)
    page = 1'b0;
    in_a = 16'h0005; in_b = 16'h0000;
    cyc(1'b1);
    run(70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
